// File: rtl/int_div_param.sv
// int_div_param: radix-2 restoring integer divider (DIVU/DIV/REMU/REM) carrying a tag, with kill and result backpressure
// Ports: clk_i clock; rst_i asynchronous active-high reset;
//   En_i/Ready_o request handshake; Op_i {remainder, signed}; OpA_i dividend; OpB_i divisor;
//   Tag_i returned on Tag_o; Kill_i aborts the operation in flight;
//   Valid_o/OutReady_i result handshake; Res_o result; Status_o {signed overflow, divide-by-zero}.
// Build option: define INT_DIV_EARLY_TERM_EN to iterate only over significant dividend bits.
module int_div_param #(
  parameter int WIDTH = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 En_i,
  input  logic [1:0]           Op_i,
  input  logic [WIDTH-1:0]     OpA_i,
  input  logic [WIDTH-1:0]     OpB_i,
  input  logic [TAG_WIDTH-1:0] Tag_i,
  input  logic                 Kill_i,
  input  logic                 OutReady_i,
  output logic                 Ready_o,
  output logic                 Valid_o,
  output logic [WIDTH-1:0]     Res_o,
  output logic [TAG_WIDTH-1:0] Tag_o,
  output logic [1:0]           Status_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic rem_op, neg_q, neg_r, accept, sgn, neg_a, neg_b, dz, ovf, az, quick, last, ge;
  logic [WIDTH-1:0] quo, div, rem, res, mag_a, mag_b, a_init, spec_res, q_new, r_new, q_fin, r_fin;
  logic [WIDTH:0] r_sh;
  logic [TAG_WIDTH-1:0] tag;
  logic [1:0] status;
  logic [CW-1:0] cnt, n;
`ifdef INT_DIV_EARLY_TERM_EN
  logic [CW-1:0] lz;
`endif
  always_comb begin
    accept = (state == IDLE) & En_i & ~Kill_i;
    sgn = Op_i[0];
    neg_a = sgn & OpA_i[WIDTH-1];
    neg_b = sgn & OpB_i[WIDTH-1];
    mag_a = neg_a ? -OpA_i : OpA_i;
    mag_b = neg_b ? -OpB_i : OpB_i;
    dz = OpB_i == '0;
    ovf = sgn & (OpA_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&OpB_i);
    az = OpA_i == '0;
    quick = dz | ovf | az;
    // divide-by-zero: quotient all-ones, remainder = dividend; overflow: quotient MIN, remainder 0
    spec_res = dz ? (Op_i[1] ? OpA_i : '1) : (ovf & ~Op_i[1]) ? OpA_i : '0;
`ifdef INT_DIV_EARLY_TERM_EN
    lz = '0;
    for (int i = 0; i < WIDTH; i++) if (mag_a[i]) lz = CW'(WIDTH - 1 - i);
    n = CW'(WIDTH) - lz;
    // align the top significant dividend bit with the MSB so it is retired first
    a_init = mag_a << lz;
`else
    n = CW'(WIDTH);
    a_init = mag_a;
`endif
    // the partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits
    r_sh = {rem, quo[WIDTH-1]};
    ge = r_sh >= {1'b0, div};
    r_new = ge ? WIDTH'(r_sh - {1'b0, div}) : r_sh[WIDTH-1:0];
    q_new = {quo[WIDTH-2:0], ge};
    q_fin = neg_q ? -q_new : q_new;
    r_fin = neg_r ? -r_new : r_new;
    last = cnt == CW'(1);
    state_nxt = state == IDLE ? (accept ? (quick ? DONE : CALC) : IDLE)
              : Kill_i ? IDLE
              : state == CALC ? (last ? DONE : CALC)
              : OutReady_i ? IDLE : DONE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rem_op <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      tag <= '0;
      div <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      res <= '0;
      status <= '0;
    end else if (accept) begin
      rem_op <= Op_i[1];
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
      tag <= Tag_i;
      div <= mag_b;
      rem <= '0;
      quo <= a_init;
      cnt <= n;
      res <= spec_res;
      status <= {ovf, dz};
    end else if (state == CALC) begin
      quo <= q_new;
      rem <= r_new;
      cnt <= cnt - CW'(1);
      if (last) res <= rem_op ? r_fin : q_fin;
    end
  assign Ready_o = state == IDLE;
  assign Valid_o = state == DONE;
  assign Res_o = Valid_o ? res : '0;
  assign Tag_o = Valid_o ? tag : '0;
  assign Status_o = Valid_o ? status : '0;
endmodule

// File: tb/tb_int_div_param.sv
// tb_int_div_param: randomized and directed self-checking bench for int_div_param against an arithmetic reference model
module tb_int_div_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [3:0] tag_in = '0;
  logic kill = 1'b0;
  logic out_ready = 1'b1;
  logic ready, valid;
  logic [31:0] res;
  logic [3:0] tag_out;
  logic [1:0] status;
  int total = 0;
  int bad = 0;
  int_div_param #(.WIDTH(32), .TAG_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .En_i(en), .Op_i(op), .OpA_i(opa), .OpB_i(opb), .Tag_i(tag_in),
    .Kill_i(kill), .OutReady_i(out_ready), .Ready_o(ready), .Valid_o(valid), .Res_o(res),
    .Tag_o(tag_out), .Status_o(status)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [1:0] st, output int lat);
    longint sa, sb, mag;
    int bits;
    if (b == 0) begin
      r = o[1] ? a : 32'hFFFF_FFFF;
      st = 2'b01;
      lat = 1;
    end else if (o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = o[1] ? 32'h0 : 32'h8000_0000;
      st = 2'b10;
      lat = 1;
    end else if (a == 0) begin
      r = 0;
      st = 2'b00;
      lat = 1;
    end else begin
      sa = o[0] ? longint'(signed'(a)) : longint'(a);
      sb = o[0] ? longint'(signed'(b)) : longint'(b);
      r = o[1] ? 32'(sa % sb) : 32'(sa / sb);
      st = 2'b00;
      mag = sa < 0 ? -sa : sa;
      bits = 0;
      while (mag > 0) begin
        bits++;
        mag = mag >> 1;
      end
`ifdef INT_DIV_EARLY_TERM_EN
      lat = bits + 1;
`else
      lat = 33;
`endif
    end
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input int hold);
    logic [31:0] er;
    logic [1:0] es;
    int el, lat;
    model(o, a, b, er, es, el);
    out_ready = hold == 0;
    @(negedge clk);
    en = 1'b1;
    op = o;
    opa = a;
    opb = b;
    tag_in = t;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      en = 1'b0;
      lat++;
    end while (!valid && lat < 100);
    chk("latency", 64'(lat), 64'(el));
    chk("res", 64'(res), 64'(er));
    chk("status", 64'(status), 64'(es));
    chk("tag", 64'(tag_out), 64'(t));
    chk("ready_in_done", 64'(ready), 64'd0);
    if (hold > 0) begin
      en = 1'b1;
      opa = 32'd77;
      opb = 32'd5;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", 64'(valid), 64'd1);
        chk("hold_ready", 64'(ready), 64'd0);
        chk("hold_res", 64'(res), 64'(er));
        chk("hold_tag", 64'(tag_out), 64'(t));
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    chk("idle_after_done", 64'({ready, valid}), 64'b10);
  endtask
  initial begin
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_outs", 64'({res, tag_out, status}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 32'd100, 32'd7, 4'd3, 0);
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 4'd1, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 4'd2, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 4'd4, 0);
    run_op(2'b01, 32'd5, 32'd0, 4'd5, 0);
    run_op(2'b10, 32'd5, 32'd0, 4'd6, 0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 0);
    run_op(2'b01, 32'd0, 32'd5, 4'd10, 0);
    run_op(2'b11, 32'd13, 32'hFFFF_FFFC, 4'd11, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'd1, 4'd12, 0);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 3 == 1) a = a >> $urandom_range(31, 0);
      if (i % 4 == 2) b = b >> $urandom_range(31, 8);
      if (i % 7 == 3) b = 32'd0;
      run_op(2'($urandom_range(3, 0)), a, b, 4'($urandom), 0);
    end
    run_op(2'b00, 32'd1000, 32'd9, 4'd13, 5);
    @(negedge clk);
    en = 1'b1;
    kill = 1'b1;
    opa = 32'd9;
    opb = 32'd3;
    @(posedge clk);
    #1;
    chk("kill_idle_blocks", 64'({ready, valid}), 64'b10);
    @(negedge clk);
    kill = 1'b0;
    op = 2'b00;
    opa = 32'hFFFF_FFFF;
    opb = 32'd3;
    @(posedge clk);
    #1;
    en = 1'b0;
    chk("calc1_busy", 64'({ready, valid}), 64'b00);
    @(posedge clk);
    #1;
    chk("calc2_busy", 64'({ready, valid}), 64'b00);
    @(posedge clk);
    #1;
    chk("calc3_busy", 64'({ready, valid}), 64'b00);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("killed_idle", 64'({ready, valid}), 64'b10);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid) break;
    end
    chk("killed_no_valid", 64'({ready, valid, res}), {31'd0, 1'b1, 1'b0, 32'd0});
    @(negedge clk);
    en = 1'b1;
    tag_in = 4'd14;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_calc", 64'({ready, valid, res, tag_out, status}), {28'd0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0});
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 32'd9, 32'd3, 4'd15, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
